mat_stream_cache: RTL
=====================

# mat_stream_cache

Parametrised matrix-operand cache that stores FPSIZE-bit elements and returns WIDTH-element vectors in row (stride 1) or column (stride STRIDE) order. A vector is gathered over several cycles, LANES elements per cycle, into an output register. It has a valid/ready request and response handshake and a single-word write port that is always available. It sits between the matrix loader, which writes it, and the systolic array input, which reads vectors from it.

## Interface
- WIDTH, 128: elements per output vector
- CACHESIZE, 256: storage depth in elements; must be a power of 2
- CACHEADDR, $clog2(CACHESIZE): address width
- FPSIZE, 16: element width in bits
- LANES, 8: elements read per cycle; WIDTH % LANES == 0
- STRIDE, 16: element stride in column mode

- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  vector read request
- req_ready  out  1  high only in IDLE
- mode  in  1  0 = row (stride 1), 1 = column (stride STRIDE); sampled at request accept
- addr  in  CACHEADDR  start element address; sampled at request accept
- wr_en  in  1  write one element
- wr_addr  in  CACHEADDR  write address
- wr_data  in  FPSIZE  write data
- out_valid  out  1  cout holds a complete vector
- out_ready  in  1  consumer accepts cout
- cout  out  WIDTH x FPSIZE  gathered vector; element i is in slice [i]

## Operation
- States: IDLE, FETCH, DONE. BEATS = WIDTH/LANES.
- IDLE: req_ready=1. On req_valid, latch addr, mode, beat=0, then go to FETCH.
- FETCH: each cycle, read elements i = beat*LANES + k for k in 0..LANES-1 into cout[i].
  - Element address = (addr + i*s) mod CACHESIZE, with s = 1 or STRIDE. Wrap-around comes from truncation to CACHEADDR bits.
  - After the beat with index BEATS-1, go to DONE and set out_valid=1.
- DONE: cout is held stable. On out_ready, clear out_valid and go to IDLE.
- Write port: the write is performed whenever wr_en=1, in any state.
- Write/read collision: if a write and a FETCH beat read the same address in the same cycle, the read returns the old value (read-before-write). The new value is visible from the next cycle on.
- Slices of cout not yet overwritten during FETCH keep the previous vector's contents.
- out_ready while not in DONE is ignored.
- Reset: state=IDLE, out_valid=0, cout=0, beat=0, latched addr/mode=0. Memory contents are not reset.
- Reset during FETCH or DONE aborts the request. No out_valid is produced for it.

## Timing
- Request accepted at edge T: beats are read at edges T+1 .. T+BEATS. out_valid is high after edge T+BEATS; with defaults that is 16 cycles.
- Response accepted at edge U: req_ready is high after edge U. Next request can be accepted at edge U+1.
- Minimum request-to-request period is BEATS+2 cycles.
- req_ready and out_valid are registered (state-decoded) with no combinational path from inputs.
- Write latency: a write at edge W is readable by a beat at edge W+1 or later.

## Structure
- Package mat_cache_pkg holds:
  - state enum {IDLE, FETCH, DONE}
  - mode constants MODE_ROW=1'b0, MODE_COL=1'b1
  - a function elem_addr(base, i, mode) returning the wrapped CACHEADDR-bit address
- Sub-module mat_cache_mem: a flop array of CACHESIZE x FPSIZE with one write port and LANES combinational read ports.
- The top level holds the FSM, beat counter, latched request and cout register.

## Test plan
- Reset, then mem[j]=j: row request addr=0 → cout[i]=i for i=0..127; out_valid rises exactly 16 cycles after accept.
- Column mode, addr=3, STRIDE=16 → cout[i]=(3+16*i) mod 256; cout[16]=3, which checks wrap-around.
- Row mode, addr=200 → cout[55]=255 and cout[56]=0 (wrap across the top).
- Write mem[5]=0xABCD in the same cycle as the beat reading address 5 → cout[5] holds the old value. A following request returns 0xABCD.
- Hold out_ready=0 for 10 cycles in DONE → cout stable, req_ready=0, extra req_valid ignored. Then set out_ready=1 → IDLE on the next edge.
- Assert reset at beat 7 of FETCH → out_valid stays 0, cout=0, state=IDLE, memory contents preserved.

Source files
------------

// File: rtl/mat_cache_pkg.sv
// Shared types and address helper for the matrix-operand stream cache.
// elem_addr wraps by masking to the cache address width.
package mat_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_COL = 1'b1;

  // Address of element idx of a vector starting at base; wraps modulo 2**addr_w.
  function automatic logic [31:0] elem_addr(
    input logic [31:0] base,
    input logic [31:0] idx,
    input logic        mode,
    input logic [31:0] stride,
    input int unsigned addr_w
  );
    logic [31:0] step;
    logic [31:0] mask;
    step = (mode == MODE_COL) ? stride : 32'd1;
    mask = (32'd1 << addr_w) - 32'd1;
    return (base + idx * step) & mask;
  endfunction

endpackage

// File: rtl/mat_cache_mem.sv
// Element storage: one synchronous write port and LANES combinational read ports.
// A read racing a write to the same address sees the pre-write contents.
module mat_cache_mem
  import mat_cache_pkg::*;
#(
  parameter int CACHESIZE = 256,
  parameter int CACHEADDR = $clog2(CACHESIZE),
  parameter int FPSIZE    = 16,
  parameter int LANES     = 8
) (
  input  logic                                i_clk,
  input  logic                                i_wr_en,
  input  logic [CACHEADDR-1:0]                i_wr_addr,
  input  logic [FPSIZE-1:0]                   i_wr_data,
  input  logic [LANES-1:0][CACHEADDR-1:0]     i_rd_addr,
  output logic [LANES-1:0][FPSIZE-1:0]        o_rd_data
);

  logic [FPSIZE-1:0] r_mem [CACHESIZE];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_rd_port
      assign o_rd_data[gi] = r_mem[i_rd_addr[gi]];
    end
  endgenerate

endmodule

// File: rtl/mat_stream_cache.sv
// Matrix-operand cache: gathers WIDTH-element row or column vectors, LANES per cycle,
// into a held output register with valid/ready request and response handshakes.
module mat_stream_cache
  import mat_cache_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int CACHESIZE = 256,
  parameter int CACHEADDR = $clog2(CACHESIZE),
  parameter int FPSIZE    = 16,
  parameter int LANES     = 8,
  parameter int STRIDE    = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic                            i_mode,
  input  logic [CACHEADDR-1:0]            i_addr,
  input  logic                            i_wr_en,
  input  logic [CACHEADDR-1:0]            i_wr_addr,
  input  logic [FPSIZE-1:0]               i_wr_data,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [WIDTH-1:0][FPSIZE-1:0]    o_cout
);

  localparam int BEATS  = WIDTH / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t                          r_state;
  logic [BEAT_W-1:0]               r_beat;
  logic [CACHEADDR-1:0]            r_addr;
  logic                            r_mode;
  logic                            r_out_valid;
  logic [WIDTH-1:0][FPSIZE-1:0]    r_cout;

  logic [LANES-1:0][IDX_W-1:0]     w_elem_idx;
  logic [LANES-1:0][CACHEADDR-1:0] w_rd_addr;
  logic [LANES-1:0][FPSIZE-1:0]    w_rd_data;
  logic                            w_last_beat;

  mat_cache_mem #(
    .CACHESIZE (CACHESIZE),
    .CACHEADDR (CACHEADDR),
    .FPSIZE    (FPSIZE),
    .LANES     (LANES)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Lane gi of the current beat serves vector element beat*LANES + gi.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_elem_idx[gi] = IDX_W'(r_beat) * IDX_W'(LANES) + IDX_W'(gi);
      assign w_rd_addr[gi]  = CACHEADDR'(elem_addr(32'(r_addr), 32'(w_elem_idx[gi]),
                                                   r_mode, 32'(STRIDE), CACHEADDR));
    end
  endgenerate

  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_addr      <= '0;
      r_mode      <= MODE_ROW;
      r_out_valid <= 1'b0;
      r_cout      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_addr  <= i_addr;
            r_mode  <= i_mode;
            r_beat  <= '0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          for (int k = 0; k < LANES; k++) begin
            r_cout[w_elem_idx[k]] <= w_rd_data[k];
          end
          if (w_last_beat) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_cout      = r_cout;

endmodule
